// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: pipelined floating-point adder/subtractor, RNE rounding, valid/ready handshake.
// Ports: clk, rst (async, active-high); in_valid/in_ready with operands a, b and sub (1: a-b);
//        out_valid/out_ready with result and the overflow, underflow, invalid flags.
// Operands are captured on acceptance, then align, add and normalise/round/pack stages follow,
// so a result appears three edges after the accepting edge. One shared enable stalls everything.
module fpu_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);
    localparam int FW = MAN_W + 3;
    localparam int MW = MAN_W + 4;
    localparam int LW = $clog2(MW + 1);
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;

    logic v0, v1, v2;
    logic [W-1:0] a0, b0;

    logic sa, sb, za, zb, ia, ib, na, nb, swap, sl, ss, spc1, inv1;
    logic [EXP_W-1:0] ea, eb, el, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0] ma, mb, ml, msm;
    logic [2*FW-1:0] wide;
    logic [MW-1:0] al;
    logic [W-1:0] word1;
    int sh;

    // Larger magnitude goes first; the smaller is shifted right with a sticky bit
    // collecting everything that falls off the guard/round positions.
    always_comb begin
        sa = a0[W-1];
        sb = b0[W-1];
        ea = a0[W-2:MAN_W];
        eb = b0[W-2:MAN_W];
        fa = a0[MAN_W-1:0];
        fb = b0[MAN_W-1:0];
        za = ea == '0;
        zb = eb == '0;
        ia = &ea && fa == '0;
        ib = &eb && fb == '0;
        na = &ea && fa != '0;
        nb = &eb && fb != '0;
        ma = za ? '0 : {1'b1, fa};
        mb = zb ? '0 : {1'b1, fb};
        swap = {eb, mb[MAN_W-1:0]} > {ea, ma[MAN_W-1:0]};
        sl = swap ? sb : sa;
        ss = swap ? sa : sb;
        el = swap ? eb : ea;
        ml = swap ? mb : ma;
        msm = swap ? ma : mb;
        diff = el - (swap ? ea : eb);
        sh = int'(diff) > FW ? FW : int'(diff);
        wide = {msm, 2'b00, {FW{1'b0}}} >> sh;
        al = {wide[2*FW-1:FW], |wide[FW-1:0]};
        inv1 = ia && ib && (sa != sb);
        spc1 = na || nb || ia || ib;
        word1 = (na || nb || inv1) ? QNAN : {ia ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    logic s1_sl, s1_ss, s1_spc, s1_inv;
    logic [EXP_W-1:0] s1_e;
    logic [MW-1:0] s1_ml, s1_ms;
    logic [W-1:0] s1_word;

    logic s2_sign, s2_zsign, s2_spc, s2_inv;
    logic [EXP_W-1:0] s2_e;
    logic [MW:0] s2_sum;
    logic [W-1:0] s2_word;

    logic cy, rnd;
    logic [LW-1:0] lz;
    logic [MW-1:0] nm;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] fr;
    logic [W-1:0] r3;
    logic [2:0] f3;
    int en, ef;

    // Flags are {overflow, underflow, invalid}; special operands bypass the datapath.
    always_comb begin
        lz = '0;
        for (int i = 0; i < MW; i++)
            if (s2_sum[i]) lz = LW'(MW - 1 - i);
        cy = s2_sum[MW];
        nm = cy ? {s2_sum[MW:2], |s2_sum[1:0]} : s2_sum[MW-1:0] << lz;
        en = int'(s2_e) + int'(cy) - int'(lz);
        rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
        mr = {1'b0, nm[MW-1:3]} + (MAN_W+2)'(rnd);
        ef = en + int'(mr[MAN_W+1]);
        fr = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        r3 = {s2_sign, EXP_W'(ef), fr};
        f3 = 3'b000;
        if (s2_spc) begin
            r3 = s2_word;
            f3 = {2'b00, s2_inv};
        end else if (s2_sum == '0) begin
            r3 = {s2_zsign, {(W-1){1'b0}}};
        end else if (en <= 0) begin
            r3 = {s2_sign, {(W-1){1'b0}}};
            f3 = 3'b010;
        end else if (ef >= EMAX) begin
            r3 = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            f3 = 3'b100;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            a0 <= '0;
            b0 <= '0;
            s1_sl <= 1'b0;
            s1_ss <= 1'b0;
            s1_spc <= 1'b0;
            s1_inv <= 1'b0;
            s1_e <= '0;
            s1_ml <= '0;
            s1_ms <= '0;
            s1_word <= '0;
            s2_sign <= 1'b0;
            s2_zsign <= 1'b0;
            s2_spc <= 1'b0;
            s2_inv <= 1'b0;
            s2_e <= '0;
            s2_sum <= '0;
            s2_word <= '0;
            result <= '0;
            {overflow, underflow, invalid} <= 3'b000;
        end else if (adv) begin
            v0 <= in_valid;
            a0 <= a;
            b0 <= {b[W-1] ^ sub, b[W-2:0]};
            v1 <= v0;
            s1_sl <= sl;
            s1_ss <= ss;
            s1_spc <= spc1;
            s1_inv <= inv1;
            s1_e <= el;
            s1_ml <= {ml, 3'b000};
            s1_ms <= al;
            s1_word <= word1;
            v2 <= v1;
            s2_sign <= s1_sl;
            s2_zsign <= s1_sl & s1_ss;
            s2_spc <= s1_spc;
            s2_inv <= s1_inv;
            s2_e <= s1_e;
            s2_sum <= (s1_sl ^ s1_ss) ? {1'b0, s1_ml} - {1'b0, s1_ms} : {1'b0, s1_ml} + {1'b0, s1_ms};
            s2_word <= s1_word;
            out_valid <= v2;
            result <= r3;
            {overflow, underflow, invalid} <= f3;
        end
    end
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb_fpu_addsub_pipe: vector table plus scoreboard bench for fpu_addsub_pipe (single and double formats).
module tb_fpu_addsub_pipe;
    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready, overflow, underflow, invalid;
    logic [31:0] a, b, result;
    logic        d_in_valid, d_in_ready, d_sub, d_out_valid, d_out_ready, d_overflow, d_underflow, d_invalid;
    logic [63:0] d_a, d_b, d_result;

    always #5 clk = ~clk;

    fpu_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    fpu_addsub_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b), .sub(d_sub),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result),
        .overflow(d_overflow), .underflow(d_underflow), .invalid(d_invalid)
    );

    int passed = 0;
    int total = 0;
    int ghost = 0;
    int delivered = 0;
    vec_t sb[$];
    vec_t vecs[18];
    vec_t idle;
    logic was_stalled = 1'b0;
    logic [31:0] held = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at posedge+1: drive, sample just before the next edge, then advance one cycle.
    task automatic step(input logic v, input vec_t t, input logic ordy, output logic acc);
        vec_t e;
        in_valid = v;
        a = t.a;
        b = t.b;
        sub = t.sub;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (was_stalled) begin
            check("stall_result", 64'(result), 64'(held));
            check("stall_valid", 64'(out_valid), 64'd1);
        end
        if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) ghost++;
            else begin
                e = sb.pop_front();
                check($sformatf("v%0d_result", e.id), 64'(result), 64'(e.r));
                check($sformatf("v%0d_flags", e.id), 64'({overflow, underflow, invalid}), 64'(e.f));
                delivered++;
            end
        end
        if (acc) sb.push_back(t);
        was_stalled = out_valid && !out_ready;
        held = result;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 20 && sb.size() > 0; k++) step(1'b0, idle, 1'b1, acc);
        check("drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic acc;
        int n, i, cyc;
        idle = '{-1, 32'h0, 32'h0, 1'b0, 32'h0, 3'b000};
        vecs[0]  = '{0,  32'h40866666, 32'h404CCCCD, 1'b0, 32'h40ECCCCC, 3'b000};
        vecs[1]  = '{1,  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
        vecs[2]  = '{2,  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
        vecs[3]  = '{3,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100};
        vecs[4]  = '{4,  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001};
        vecs[5]  = '{5,  32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
        vecs[6]  = '{6,  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010};
        vecs[7]  = '{7,  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
        vecs[8]  = '{8,  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000};
        vecs[9]  = '{9,  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
        vecs[10] = '{10, 32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000};
        vecs[11] = '{11, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
        vecs[12] = '{12, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000};
        vecs[13] = '{13, 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000};
        vecs[14] = '{14, 32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 3'b000};
        vecs[15] = '{15, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000};
        vecs[16] = '{16, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000};
        vecs[17] = '{17, 32'h4B800000, 32'h3F800000, 1'b1, 32'h4B7FFFFF, 3'b000};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({overflow, underflow, invalid}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // exact latency of a single operation
        in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b; sub = vecs[0].sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'd3);
        check("lat_result", 64'(result), 64'h40ECCCCC);
        check("lat_flags", 64'({overflow, underflow, invalid}), 64'd0);
        @(posedge clk);
        #1;

        // full table, back to back
        for (int k = 0; k < 18; k++) step(1'b1, vecs[k], 1'b1, acc);
        drain();

        // 8-deep stream with a 4-cycle downstream stall
        delivered = 0;
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 40) begin
            step(1'b1, vecs[i], !(cyc >= 4 && cyc < 8), acc);
            if (acc) i++;
            cyc++;
        end
        drain();
        check("stream_count", 64'(delivered), 64'd8);

        // reset with three operations in flight
        for (int k = 8; k < 11; k++) step(1'b1, vecs[k], 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_flags", 64'({overflow, underflow, invalid}), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        was_stalled = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ghost = 0;
        for (int k = 0; k < 8; k++) step(1'b0, idle, 1'b1, acc);
        check("no_ghost_after_rst", 64'(ghost), 64'd0);
        step(1'b1, vecs[12], 1'b1, acc);
        drain();

        // double-precision instance
        d_in_valid = 1'b1; d_a = 64'h3FF0000000000000; d_b = 64'h4000000000000000; d_sub = 1'b0;
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        n = 0;
        while (!d_out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("dbl_latency", 64'(n), 64'd3);
        check("dbl_result", d_result, 64'h4008000000000000);
        check("dbl_flags", 64'({d_overflow, d_underflow, d_invalid}), 64'd0);

        check("ghost", 64'(ghost), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_pipe.md
# fpu_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor: the successor to the combinational single-precision adder `fpu_sp_adder`. It generalises the operand format through exponent and mantissa width parameters and adds an add/subtract mode select. It has three registered stages with a valid/ready handshake, round-to-nearest-even and separate overflow, underflow and invalid flags. It sits in the FPU datapath between the operand issue logic and the result writeback.

## Interface
- `EXP_W`, 8, exponent field width (≥4).
- `MAN_W`, 23, stored fraction width (≥4); word width W = 1+EXP_W+MAN_W (default 32; 11/52 gives double).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid this cycle.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`, `b`  in  W each  operands; sign at MSB, exponent next, fraction at LSBs.
- `sub`  in  1  0: a+b, 1: a−b (flip sign of b before processing).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `result`  out  W  rounded sum.
- `overflow`, `underflow`, `invalid`  out  1 each  flags qualified by out_valid.

## Operation
- The block has one enable: `adv = !out_valid || out_ready`. All stage registers and their valid bits load only when `adv` is high. `in_ready = adv`, combinationally.
- A transfer occurs when `in_valid && in_ready`. Otherwise a bubble (valid=0) enters stage 1 when `adv` is high.
- Stage 1 (unpack/align):
  - Classify each operand as zero (exponent 0; subnormals are flushed to signed zero), inf, NaN or normal.
  - Prepend the hidden 1.
  - Swap operands so the larger magnitude is first.
  - Right-shift the smaller by the exponent difference into a MAN_W+4-bit field: hidden bit, fraction, guard, round, and a sticky bit that ORs all shifted-out bits. Shifts ≥ MAN_W+3 leave sticky only.
- Stage 2 (add):
  - Effective subtract = sign(a) XOR sign(b'). Add or subtract the magnitudes; no negative result is possible after the swap.
  - Result sign = sign of the larger operand.
- Stage 3 (normalise/round/pack):
  - On carry-out, shift right 1, fold into sticky and increment the exponent. Otherwise left-shift by leading-zero count and decrement the exponent.
  - Round to nearest even using guard/round/sticky. If rounding carries out, renormalise.
- Special cases:
  - Any NaN input → canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0. `invalid`=0 for a NaN input.
  - inf ± inf of opposite effective sign → canonical qNaN, `invalid`=1.
  - inf with a finite operand → inf of that sign. inf+inf of the same sign → that inf.
  - Exact zero sum → +0, except when both operands are −0 after the `sub` flip, which gives −0.
  - Exponent ≥ all-ones after rounding → signed inf, `overflow`=1.
  - Normalised exponent ≤ 0 (subnormal range) → signed zero, `underflow`=1.
- At most one flag is set per result.

## Timing
- Latency is 3 cycles with no stall: operands accepted at edge N give `out_valid` and `result` after edge N+3.
- Throughput is one result per cycle while `out_ready`=1.
- Stall: when `out_valid && !out_ready`, every stage holds. `result` and flags stay stable until accepted, and `in_ready`=0.
- Bubbles are not compressed. A stall with valid data in stages 1–2 holds them in place.
- Reset, asynchronous at any time including mid-pipeline:
  - All valid bits clear, so `out_valid`=0 and in-flight operands are discarded.
  - `result`=0, `overflow`=`underflow`=`invalid`=0.
  - `in_ready`=1 immediately.
- Simultaneous accept and output in the same cycle is legal and required for full throughput.

## Test plan
- Default format, `a`=0x40866666 (4.2), `b`=0x404CCCCD (3.2), `sub`=0 → `result`=0x40ECCCCC (tie rounded to even), no flags, exactly 3 cycles later.
- `a`=0x3F800000, `b`=0x3F800000, `sub`=1 → 0x00000000. `a`=`b`=0x80000000, `sub`=0 → 0x80000000.
- Overflow, invalid and NaN:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `overflow`=1.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, `invalid`=1.
  - 0x7FA00000 + 0x3F800000 → 0x7FC00000, `invalid`=0.
- Underflow: 0x00800001 − 0x00800000 → 0x00000000 with `underflow`=1.
- Handshake and reset:
  - Stream 8 back-to-back operations; hold `out_ready`=0 for 4 cycles mid-stream. All 8 results must arrive in order with no loss or duplication, and `result` must stay stable while stalled.
  - Assert `rst` with 3 operations in flight → `out_valid` drops at once, and none of those results appear after reset.
- `EXP_W`=11, `MAN_W`=52: 0x3FF0000000000000 + 0x4000000000000000 → 0x4008000000000000 (1.0+2.0=3.0), no flags.
